branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
- Parametrised successor to the combinational branch-target adder.
- Computes the branch target as PC + offset and evaluates the branch condition.
- Compares the outcome with the front-end prediction and reports the correct next PC plus a mispredict flag.
- Two-stage valid/ready pipeline between decode/execute and the fetch redirect logic; also carries saturating resolve and mispredict counters.

Parameters:
- XLEN, 32, datapath width of PC, offset, operands and target.
- ALIGN_BITS, 2, number of target LSBs that must be zero for the target to be aligned; 0 disables the check.
- INSN_BYTES, 4, increment used for the fall-through PC.
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- flush  in  1  synchronous pipeline kill.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid && in_ready.
- in_pc  in  XLEN  PC of the branch.
- in_offset  in  XLEN  sign-extended byte offset, two's complement.
- in_rs1  in  XLEN  first compare operand.
- in_rs2  in  XLEN  second compare operand.
- in_op  in  3  000 BEQ, 001 BNE, 010 JAL, 011 reserved, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU.
- in_pred_taken  in  1  front-end prediction.
- in_pred_target  in  XLEN  predicted target, meaningful only if in_pred_taken.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_taken  out  1  resolved direction.
- out_target  out  XLEN  PC + offset.
- out_next_pc  out  XLEN  out_target if taken, else PC + INSN_BYTES.
- out_mispredict  out  1  redirect required.
- out_misaligned  out  1  taken and target misaligned.
- out_illegal  out  1  in_op == 011.
- cnt_resolved  out  CNT_W  results delivered.
- cnt_mispredict  out  CNT_W  mispredicts delivered.

Behaviour:
- Reset (rst_n low at a clk edge): all stage valid bits, all outputs and both counters go to 0. in_ready reads 0 while rst_n is low.
- Stage S1 registers:
  - sum = in_pc + in_offset, modulo 2^XLEN; wrap-around is silent, so 0x7FFFFFFF + 1 = 0x80000000.
  - taken:
    - BEQ/BNE use equality.
    - BLT/BGE use a signed compare; BLTU/BGEU use an unsigned compare.
    - JAL is always taken.
    - Reserved 011 gives taken = 0 and illegal = 1.
  - in_pc + INSN_BYTES, modulo 2^XLEN.
  - the prediction fields.
- Stage S2 registers:
  - next_pc.
  - mispredict = (taken != pred_taken) || (taken && pred_taken && pred_target != target).
  - misaligned = taken && target[ALIGN_BITS-1:0] != 0.
  - illegal.
  - A misaligned or illegal result still reports mispredict per the formula above.
- Elastic pipeline:
  - S2 loads when it is empty or out_ready is high.
  - S1 loads when S1 is empty or S2 loads.
  - in_ready = !flush && (!s1_valid || s2 loads).
- Timing: latency is 2 cycles from acceptance to out_valid; throughput is 1 per cycle while out_ready is high.
- Backpressure: while out_valid && !out_ready, all out_* fields hold stable and no data is lost.
- Flush:
  - Clears both valid bits at the edge; out_valid is 0 in the following cycle.
  - A handshake coinciding with flush is not accepted (in_ready = 0).
  - An output coinciding with flush is discarded and not counted.
  - Counters are not cleared.
- Counters:
  - cnt_resolved increments on each out_valid && out_ready && !flush.
  - cnt_mispredict increments on the same condition when out_mispredict is also 1.
  - Both saturate at 2^CNT_W-1.
- Output fields while out_valid is 0 are don't-care, except after reset, where they are 0.

Decomposition:
- Shared package branch_pkg holds:
  - the br_op_e enum with the encodings above;
  - the BR_OP_RESERVED constant;
  - a packed struct br_result_t (taken, target, next_pc, mispredict, misaligned, illegal).
- One sub-module, br_cond_eval: combinational op/rs1/rs2 to taken/illegal, reused by the ALU bypass path.
- Counters and pipeline stay in the top module.

Test Plan:
- Wrap-around and fall-through: PC=0x00000004, off=0x00000010, BEQ rs1=rs2=5, pred_taken=1, pred_target=0x14 -> taken=1, target=0x14, next_pc=0x14, mispredict=0. Then PC=0x7FFFFFFF, off=1, BNE rs1=rs2 -> target=0x80000000, taken=0, next_pc=0x80000003.
- Negative offset with signed vs unsigned compare: PC=0x10, off=0xFFFFFFF0, rs1=0xFFFFFFFF, rs2=1. BLT -> taken=1, target=0x00000000. BLTU with pred_taken=1 -> taken=0, next_pc=0x14, mispredict=1.
- Target mispredict and alignment checks:
  - JAL PC=0x20, off=4, pred_taken=1, pred_target=0x30 -> mispredict=1, next_pc=0x24.
  - off=2 -> misaligned=1.
  - in_op=011 -> illegal=1, taken=0.
- Backpressure: issue 3 back-to-back requests with out_ready low for 4 cycles -> in_ready drops after 2 accepted; the first result holds stable; release out_ready -> results in order, no loss, cnt_resolved=3.
- Flush with 2 in flight and in_valid high -> out_valid=0 next cycle, the flush-cycle request is not accepted, counters unchanged. Repeat with rst_n low mid-stream for one edge -> all outputs and counters are 0.
- Counter saturation with CNT_W=2: 5 mispredicting results -> cnt_mispredict and cnt_resolved stick at 3.

Source files
------------

// File: rtl/branch_pkg.sv
// Branch resolution shared types: op encodings and the resolved-result record.
package branch_pkg;

   localparam int unsigned BR_XLEN        = 32;
   localparam logic [2:0]  BR_OP_RESERVED = 3'b011;

   typedef enum logic [2:0] {
      BR_BEQ  = 3'b000,
      BR_BNE  = 3'b001,
      BR_JAL  = 3'b010,
      BR_RSVD = BR_OP_RESERVED,
      BR_BLT  = 3'b100,
      BR_BGE  = 3'b101,
      BR_BLTU = 3'b110,
      BR_BGEU = 3'b111
   } br_op_e;

   typedef struct packed {
      logic               taken;
      logic [BR_XLEN-1:0] target;
      logic [BR_XLEN-1:0] next_pc;
      logic               mispredict;
      logic               misaligned;
      logic               illegal;
   } br_result_t;

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Request/result channel between decode/execute (master) and the branch resolve unit (slave).
interface branch_resolve_unit_if #(
   parameter int unsigned XLEN = 32
);
   logic            in_valid;
   logic            in_ready;
   logic [XLEN-1:0] in_pc;
   logic [XLEN-1:0] in_offset;
   logic [XLEN-1:0] in_rs1;
   logic [XLEN-1:0] in_rs2;
   logic [2:0]      in_op;
   logic            in_pred_taken;
   logic [XLEN-1:0] in_pred_target;
   logic            out_valid;
   logic            out_ready;
   logic            out_taken;
   logic [XLEN-1:0] out_target;
   logic [XLEN-1:0] out_next_pc;
   logic            out_mispredict;
   logic            out_misaligned;
   logic            out_illegal;

   modport master (
      output in_valid, in_pc, in_offset, in_rs1, in_rs2, in_op, in_pred_taken, in_pred_target,
      output out_ready,
      input  in_ready,
      input  out_valid, out_taken, out_target, out_next_pc, out_mispredict, out_misaligned, out_illegal
   );

   modport slave (
      input  in_valid, in_pc, in_offset, in_rs1, in_rs2, in_op, in_pred_taken, in_pred_target,
      input  out_ready,
      output in_ready,
      output out_valid, out_taken, out_target, out_next_pc, out_mispredict, out_misaligned, out_illegal
   );
endinterface

// File: rtl/br_cond_eval.sv
// Combinational branch condition: op + operands -> taken / illegal. No state, no handshake.
module br_cond_eval
   import branch_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  br_op_e          op_i,
   input  logic [XLEN-1:0] rs1_i,
   input  logic [XLEN-1:0] rs2_i,
   output logic            taken_o,
   output logic            illegal_o
);

   always_comb begin
      taken_o   = 1'b0;
      illegal_o = 1'b0;
      case (op_i)
         BR_BEQ:  taken_o = (rs1_i == rs2_i);
         BR_BNE:  taken_o = (rs1_i != rs2_i);
         BR_JAL:  taken_o = 1'b1;
         BR_RSVD: illegal_o = 1'b1;
         BR_BLT:  taken_o = ($signed(rs1_i) <  $signed(rs2_i));
         BR_BGE:  taken_o = ($signed(rs1_i) >= $signed(rs2_i));
         BR_BLTU: taken_o = (rs1_i <  rs2_i);
         BR_BGEU: taken_o = (rs1_i >= rs2_i);
         default: ;
      endcase
   end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve: target/condition in S1, mispredict/next-PC in S2; 2-cycle latency, 1/cycle.
// Elastic valid/ready: S2 holds stable while out_ready is low, in_ready drops once both stages are full.
module branch_resolve_unit
   import branch_pkg::*;
#(
   parameter int unsigned XLEN       = 32,
   parameter int unsigned ALIGN_BITS = 2,
   parameter int unsigned INSN_BYTES = 4,
   parameter int unsigned CNT_W      = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    flush,
   branch_resolve_unit_if.slave    bus,
   output logic [CNT_W-1:0]        cnt_resolved,
   output logic [CNT_W-1:0]        cnt_mispredict
);

   localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'((64'd1 << ALIGN_BITS) - 64'd1);

   logic            s1_vld_q;
   logic [XLEN-1:0] s1_target_q;
   logic [XLEN-1:0] s1_fall_q;
   logic            s1_taken_q;
   logic            s1_illegal_q;
   logic            s1_pred_taken_q;
   logic [XLEN-1:0] s1_pred_target_q;

   logic            s2_vld_q;
   logic            s2_taken_q;
   logic [XLEN-1:0] s2_target_q;
   logic [XLEN-1:0] s2_next_pc_q;
   logic            s2_mis_q;
   logic            s2_misal_q;
   logic            s2_ill_q;

   logic [CNT_W-1:0] cnt_res_q, cnt_res_d;
   logic [CNT_W-1:0] cnt_mis_q, cnt_mis_d;

   logic s2_load, s1_load, in_rdy, accept, fire;
   logic cond_taken, cond_illegal;
   logic s1_mispredict, s1_misaligned;

   br_cond_eval #(.XLEN(XLEN)) u_cond (
      .op_i      (br_op_e'(bus.in_op)),
      .rs1_i     (bus.in_rs1),
      .rs2_i     (bus.in_rs2),
      .taken_o   (cond_taken),
      .illegal_o (cond_illegal)
   );

   assign s2_load = !s2_vld_q || bus.out_ready;
   assign s1_load = !s1_vld_q || s2_load;
   assign in_rdy  = rst_n && !flush && s1_load;
   assign accept  = bus.in_valid && in_rdy;
   assign fire    = s2_vld_q && bus.out_ready && !flush;

   // A target mismatch only matters when both sides agree the branch is taken.
   assign s1_mispredict = (s1_taken_q != s1_pred_taken_q) ||
                          (s1_taken_q && s1_pred_taken_q && (s1_pred_target_q != s1_target_q));
   assign s1_misaligned = s1_taken_q && |(s1_target_q & ALIGN_MASK);

   always_comb begin
      cnt_res_d = cnt_res_q;
      cnt_mis_d = cnt_mis_q;
      if (fire) begin
         if (cnt_res_q != '1)             cnt_res_d = cnt_res_q + CNT_W'(1);
         if (s2_mis_q && cnt_mis_q != '1) cnt_mis_d = cnt_mis_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_vld_q         <= 1'b0;
         s1_target_q      <= '0;
         s1_fall_q        <= '0;
         s1_taken_q       <= 1'b0;
         s1_illegal_q     <= 1'b0;
         s1_pred_taken_q  <= 1'b0;
         s1_pred_target_q <= '0;
         s2_vld_q         <= 1'b0;
         s2_taken_q       <= 1'b0;
         s2_target_q      <= '0;
         s2_next_pc_q     <= '0;
         s2_mis_q         <= 1'b0;
         s2_misal_q       <= 1'b0;
         s2_ill_q         <= 1'b0;
         cnt_res_q        <= '0;
         cnt_mis_q        <= '0;
      end else begin
         if (flush) begin
            s1_vld_q <= 1'b0;
            s2_vld_q <= 1'b0;
         end else begin
            if (s1_load) s1_vld_q <= accept;
            if (s2_load) s2_vld_q <= s1_vld_q;
         end
         if (accept) begin
            s1_target_q      <= bus.in_pc + bus.in_offset;
            s1_fall_q        <= bus.in_pc + XLEN'(INSN_BYTES);
            s1_taken_q       <= cond_taken;
            s1_illegal_q     <= cond_illegal;
            s1_pred_taken_q  <= bus.in_pred_taken;
            s1_pred_target_q <= bus.in_pred_target;
         end
         if (s2_load && s1_vld_q && !flush) begin
            s2_taken_q   <= s1_taken_q;
            s2_target_q  <= s1_target_q;
            s2_next_pc_q <= s1_taken_q ? s1_target_q : s1_fall_q;
            s2_mis_q     <= s1_mispredict;
            s2_misal_q   <= s1_misaligned;
            s2_ill_q     <= s1_illegal_q;
         end
         cnt_res_q <= cnt_res_d;
         cnt_mis_q <= cnt_mis_d;
      end
   end

   assign bus.in_ready       = in_rdy;
   assign bus.out_valid      = s2_vld_q;
   assign bus.out_taken      = s2_taken_q;
   assign bus.out_target     = s2_target_q;
   assign bus.out_next_pc    = s2_next_pc_q;
   assign bus.out_mispredict = s2_mis_q;
   assign bus.out_misaligned = s2_misal_q;
   assign bus.out_illegal    = s2_ill_q;
   assign cnt_resolved       = cnt_res_q;
   assign cnt_mispredict     = cnt_mis_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboarded bench: driver pushes model results on acceptance, negedge monitor pops on output handshake.
`timescale 1ns/1ps
module tb_branch_resolve_unit;
   import branch_pkg::*;

   typedef struct {
      logic [31:0] pc, off, rs1, rs2;
      logic [2:0]  op;
      logic        pt;
      logic [31:0] ptgt;
   } req_t;

   localparam longint TWO32 = 64'h1_0000_0000;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic flush = 1'b0;
   logic [15:0] cnt_res, cnt_mis;
   logic [1:0]  scnt_res, scnt_mis;

   branch_resolve_unit_if #(.XLEN(32)) bus ();
   branch_resolve_unit_if #(.XLEN(32)) bus_s ();

   branch_resolve_unit #(.XLEN(32), .ALIGN_BITS(2), .INSN_BYTES(4), .CNT_W(16)) u_dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus),
      .cnt_resolved(cnt_res), .cnt_mispredict(cnt_mis)
   );
   branch_resolve_unit #(.XLEN(32), .ALIGN_BITS(2), .INSN_BYTES(4), .CNT_W(2)) u_sat (
      .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus_s),
      .cnt_resolved(scnt_res), .cnt_mispredict(scnt_mis)
   );

   assign bus_s.in_valid       = bus.in_valid;
   assign bus_s.in_pc          = bus.in_pc;
   assign bus_s.in_offset      = bus.in_offset;
   assign bus_s.in_rs1         = bus.in_rs1;
   assign bus_s.in_rs2         = bus.in_rs2;
   assign bus_s.in_op          = bus.in_op;
   assign bus_s.in_pred_taken  = bus.in_pred_taken;
   assign bus_s.in_pred_target = bus.in_pred_target;
   assign bus_s.out_ready      = bus.out_ready;

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;
   int n_acc = 0;
   br_result_t exp_q[$];
   bit mon_en = 0;
   bit rnd_done = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic req_t mk(input logic [31:0] pc, off, rs1, rs2, input logic [2:0] op,
                               input logic pt, input logic [31:0] ptgt);
      req_t r;
      r.pc = pc; r.off = off; r.rs1 = rs1; r.rs2 = rs2; r.op = op; r.pt = pt; r.ptgt = ptgt;
      return r;
   endfunction

   // Reference: operands interpreted as integers, targets computed modulo 2^32.
   function automatic br_result_t model(input req_t r);
      br_result_t e;
      longint ua, ub, sa, sb, sum, fall;
      bit t;
      ua = longint'({32'd0, r.rs1});
      ub = longint'({32'd0, r.rs2});
      sa = (ua >= TWO32 / 2) ? ua - TWO32 : ua;
      sb = (ub >= TWO32 / 2) ? ub - TWO32 : ub;
      sum  = (longint'({32'd0, r.pc}) + longint'({32'd0, r.off})) % TWO32;
      fall = (longint'({32'd0, r.pc}) + 4) % TWO32;
      case (r.op)
         3'd0: t = (ua == ub);
         3'd1: t = (ua != ub);
         3'd2: t = 1'b1;
         3'd4: t = (sa < sb);
         3'd5: t = (sa >= sb);
         3'd6: t = (ua < ub);
         3'd7: t = (ua >= ub);
         default: t = 1'b0;
      endcase
      e.taken      = t;
      e.target     = sum[31:0];
      e.next_pc    = t ? sum[31:0] : fall[31:0];
      e.illegal    = (r.op == 3'd3);
      e.misaligned = t && (sum % 4 != 0);
      e.mispredict = (t != r.pt) || (t && r.pt && (r.ptgt != sum[31:0]));
      return e;
   endfunction

   function automatic br_result_t cur_out();
      br_result_t a;
      a.taken = bus.out_taken; a.target = bus.out_target; a.next_pc = bus.out_next_pc;
      a.mispredict = bus.out_mispredict; a.misaligned = bus.out_misaligned; a.illegal = bus.out_illegal;
      return a;
   endfunction

   function automatic req_t cur_in();
      return mk(bus.in_pc, bus.in_offset, bus.in_rs1, bus.in_rs2, bus.in_op,
                bus.in_pred_taken, bus.in_pred_target);
   endfunction

   // Monitor / scoreboard
   int m_res = 0, m_mis = 0, ms_res = 0, ms_mis = 0;
   bit m_known = 0, rst_low_prev = 0, flush_prev = 0, hold_prev = 0;
   br_result_t held;

   always @(negedge clk) begin
      if (mon_en) begin
         if (rst_low_prev) begin
            m_res = 0; m_mis = 0; ms_res = 0; ms_mis = 0; m_known = 1;
            chk("reset_outputs", {bus.out_valid, cur_out()}, '0);
         end
         if (flush_prev) chk("flush_clears_valid", bus.out_valid, 1'b0);
         if (hold_prev) begin
            chk("hold_valid", bus.out_valid, 1'b1);
            chk("hold_fields", cur_out(), held);
         end
         if (m_known) begin
            chk("cnt_resolved", cnt_res, m_res);
            chk("cnt_mispredict", cnt_mis, m_mis);
            chk("sat_cnt_resolved", scnt_res, ms_res);
            chk("sat_cnt_mispredict", scnt_mis, ms_mis);
         end
         if (!rst_n || flush) begin
            chk(!rst_n ? "in_ready_reset" : "in_ready_flush", bus.in_ready, 1'b0);
            exp_q.delete();
         end else begin
            if (bus.out_valid && bus.out_ready) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_output", 1'b1, 1'b0);
               end else begin
                  br_result_t e;
                  e = exp_q.pop_front();
                  chk("result", cur_out(), e);
                  m_res  = (m_res == 65535) ? m_res : m_res + 1;
                  ms_res = (ms_res == 3) ? ms_res : ms_res + 1;
                  if (e.mispredict) begin
                     m_mis  = (m_mis == 65535) ? m_mis : m_mis + 1;
                     ms_mis = (ms_mis == 3) ? ms_mis : ms_mis + 1;
                  end
               end
            end
            if (bus.in_valid && bus.in_ready) begin
               exp_q.push_back(model(cur_in()));
               n_acc++;
            end
         end
         hold_prev    = rst_n && !flush && bus.out_valid && !bus.out_ready;
         held         = cur_out();
         rst_low_prev = !rst_n;
         flush_prev   = flush && rst_n;
      end
   end

   // Driver: called just after a posedge; returns just after the accepting posedge.
   task automatic set_req(input req_t r);
      bus.in_pc = r.pc; bus.in_offset = r.off; bus.in_rs1 = r.rs1; bus.in_rs2 = r.rs2;
      bus.in_op = r.op; bus.in_pred_taken = r.pt; bus.in_pred_target = r.ptgt;
   endtask

   task automatic send(input req_t r);
      int n = 0;
      set_req(r);
      bus.in_valid = 1'b1;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.in_ready && n < 60);
      if (!bus.in_ready) chk("send_timeout", 1'b0, 1'b1);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0; flush = 1'b0; bus.in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(posedge clk);
         n++;
      end
      #1;
      chk("drain_empty", exp_q.size(), 0);
   endtask

   task automatic run_one(input string name, input req_t r, input br_result_t e);
      send(r);
      @(negedge clk);
      chk({name, "_lat1"}, bus.out_valid, 1'b0);
      @(negedge clk);
      chk({name, "_lat2"}, bus.out_valid, 1'b1);
      chk(name, cur_out(), e);
      @(posedge clk); #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] c_snap;
      int acc0;
      logic [31:0] pool [6];
      bus.in_valid = 1'b0; bus.out_ready = 1'b1;
      set_req(mk(0, 0, 0, 0, 0, 0, 0));
      mon_en = 1;
      apply_reset();

      // Directed results
      run_one("beq_taken", mk(32'h4, 32'h10, 5, 5, 3'd0, 1, 32'h14),
              br_result_t'{1'b1, 32'h14, 32'h14, 1'b0, 1'b0, 1'b0});
      run_one("bne_wrap", mk(32'h7FFF_FFFF, 32'h1, 9, 9, 3'd1, 0, 0),
              br_result_t'{1'b0, 32'h8000_0000, 32'h8000_0003, 1'b0, 1'b0, 1'b0});
      run_one("blt_neg", mk(32'h10, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 1, 3'd4, 1, 0),
              br_result_t'{1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0});
      run_one("bltu_neg", mk(32'h10, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 1, 3'd6, 1, 0),
              br_result_t'{1'b0, 32'h0, 32'h14, 1'b1, 1'b0, 1'b0});
      run_one("bge_neg", mk(32'h10, 32'hFFFF_FFF0, 1, 32'hFFFF_FFFF, 3'd5, 0, 0),
              br_result_t'{1'b1, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0});
      run_one("jal_tgt_mis", mk(32'h20, 32'h4, 0, 0, 3'd2, 1, 32'h30),
              br_result_t'{1'b1, 32'h24, 32'h24, 1'b1, 1'b0, 1'b0});
      run_one("jal_misal", mk(32'h20, 32'h2, 0, 0, 3'd2, 1, 32'h22),
              br_result_t'{1'b1, 32'h22, 32'h22, 1'b0, 1'b1, 1'b0});
      run_one("rsvd_illegal", mk(32'h40, 32'h8, 3, 3, 3'd3, 0, 0),
              br_result_t'{1'b0, 32'h48, 32'h44, 1'b0, 1'b0, 1'b1});
      drain();

      // Backpressure: 3 back-to-back with out_ready low for 4 cycles
      apply_reset();
      bus.out_ready = 1'b0;
      acc0 = n_acc;
      fork
         begin
            send(mk(32'h100, 32'h8, 1, 1, 3'd0, 1, 32'h108));
            send(mk(32'h200, 32'hC, 1, 2, 3'd0, 1, 32'h20C));
            send(mk(32'h300, 32'h10, 7, 7, 3'd2, 0, 0));
         end
         begin
            repeat (4) @(negedge clk);
            chk("bp_accepted", n_acc - acc0, 2);
            chk("bp_in_ready_low", bus.in_ready, 1'b0);
            @(posedge clk); #1 bus.out_ready = 1'b1;
         end
      join
      drain();
      @(negedge clk);
      chk("bp_cnt_resolved", cnt_res, 16'd3);
      @(posedge clk); #1;

      // Flush with two in flight and a request pending
      bus.out_ready = 1'b0;
      send(mk(32'h400, 32'h4, 0, 0, 3'd2, 0, 0));
      send(mk(32'h500, 32'h4, 0, 0, 3'd2, 0, 0));
      set_req(mk(32'h600, 32'h4, 0, 0, 3'd2, 0, 0));
      bus.in_valid = 1'b1;
      flush = 1'b1;
      @(negedge clk);
      chk("flush_in_ready", bus.in_ready, 1'b0);
      c_snap = cnt_res;
      @(posedge clk); #1;
      flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
      @(negedge clk);
      chk("flush_out_valid", bus.out_valid, 1'b0);
      chk("flush_cnt_kept", cnt_res, c_snap);
      repeat (2) @(negedge clk);
      chk("flush_nothing_left", bus.out_valid, 1'b0);
      @(posedge clk); #1;

      // Reset mid-stream
      send(mk(32'h700, 32'h4, 0, 0, 3'd2, 1, 0));
      send(mk(32'h800, 32'h4, 0, 0, 3'd2, 1, 0));
      rst_n = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      chk("midrst_out_valid", bus.out_valid, 1'b0);
      chk("midrst_cnt_res", cnt_res, 16'd0);
      chk("midrst_cnt_mis", cnt_mis, 16'd0);
      chk("midrst_target", bus.out_target, 32'd0);
      @(posedge clk); #1;

      // Saturation on the narrow-counter instance
      apply_reset();
      for (int i = 0; i < 5; i++) send(mk(32'h1000 + 32'(i * 4), 32'h40, 1, 2, 3'd0, 1, 32'h1040));
      drain();
      @(negedge clk);
      chk("sat_res_stuck", scnt_res, 2'd3);
      chk("sat_mis_stuck", scnt_mis, 2'd3);
      chk("wide_res", cnt_res, 16'd5);
      chk("wide_mis", cnt_mis, 16'd5);
      @(posedge clk); #1;

      // Randomized traffic with backpressure and occasional flush
      pool[0] = 32'h0; pool[1] = 32'h1; pool[2] = 32'hFFFF_FFFF;
      pool[3] = 32'h8000_0000; pool[4] = 32'h7FFF_FFFF; pool[5] = 32'h5;
      fork
         begin
            for (int i = 0; i < 400; i++) begin
               req_t r;
               int o;
               o = $urandom_range(0, 511) - 256;
               r.pc   = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
               r.off  = ($urandom_range(0, 3) == 0) ? 32'(o) : (32'(o) & 32'hFFFF_FFFC);
               r.rs1  = ($urandom_range(0, 2) == 0) ? $urandom : pool[$urandom_range(0, 5)];
               r.rs2  = ($urandom_range(0, 2) == 0) ? $urandom : pool[$urandom_range(0, 5)];
               r.op   = 3'($urandom_range(0, 7));
               r.pt   = 1'($urandom_range(0, 1));
               r.ptgt = ($urandom_range(0, 1) == 0) ? r.pc + r.off : $urandom;
               send(r);
               repeat ($urandom_range(0, 2)) @(posedge clk);
               #1;
            end
            rnd_done = 1;
         end
         begin
            while (!rnd_done) begin
               @(posedge clk); #1;
               bus.out_ready = ($urandom_range(0, 3) != 0);
            end
            bus.out_ready = 1'b1;
         end
         begin
            while (!rnd_done) begin
               @(posedge clk); #1;
               flush = ($urandom_range(0, 39) == 0);
            end
            flush = 1'b0;
         end
      join
      drain();
      repeat (3) @(posedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
